// File: rtl/mem_ctrl_pkg.sv
// Shared types, default parameters and boot ROM image for the handshake memory controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mem_state_t;

  localparam int DEF_DW         = 16;
  localparam int DEF_AW         = 16;
  localparam int DEF_DEPTH      = 256;
  localparam int DEF_PROG_WORDS = 8;
  localparam int DEF_RD_LAT     = 2;
  localparam int DEF_WR_LAT     = 1;

  localparam int ROM_WORDS = 8;
  localparam logic [15:0] BOOT_ROM [0:ROM_WORDS-1] = '{
    16'hB241, 16'h607E, 16'h1043, 16'h5047,
    16'h9043, 16'h607F, 16'hD0C1, 16'hC042
  };

endpackage

// File: rtl/mem_ctrl_array.sv
// RAM storage: synchronous write, combinational read sampled by the controller at the completion edge.
module mem_ctrl_array #(
  parameter int DW    = 16,
  parameter int IW    = 8,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] idx,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/mem_ctrl_hs.sv
// EN/MFC handshake memory controller with boot ROM overlay and range checking.
// Optional MEM_CTRL_ERR_EN adds an err output flagging ROM writes and out-of-range accesses.
module mem_ctrl_hs
  import mem_ctrl_pkg::*;
#(
  parameter int DW         = DEF_DW,
  parameter int AW         = DEF_AW,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int PROG_WORDS = DEF_PROG_WORDS,
  parameter int RD_LAT     = DEF_RD_LAT,
  parameter int WR_LAT     = DEF_WR_LAT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          rw,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] datain,
  output logic [DW-1:0] dataout,
  output logic          mfc,
  output logic          busy
`ifdef MEM_CTRL_ERR_EN
  ,output logic         err
`endif
);

  localparam int IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MAXLAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CW     = $clog2(MAXLAT + 1);
  localparam logic [CW-1:0] RD_CNT = CW'(RD_LAT - 1);
  localparam logic [CW-1:0] WR_CNT = CW'(WR_LAT - 1);
  // One extra bit so DEPTH == 2**AW still compares correctly.
  localparam logic [AW:0] DEPTH_X = (AW+1)'(DEPTH);
  localparam logic [AW:0] PROG_X  = (AW+1)'(PROG_WORDS);

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    logic [DW+15:0] ext;
    ext = '0;
    if ({1'b0, a} < (AW+1)'(ROM_WORDS)) ext[15:0] = BOOT_ROM[a[2:0]];
    return ext[DW-1:0];
  endfunction

  mem_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mfc_q, mfc_d, busy_q, busy_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          rw_q, rw_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] ram_rdata;
  logic          in_rom, in_range, complete, ram_we;
`ifdef MEM_CTRL_ERR_EN
  logic          err_q, err_d;
`endif

  always_comb begin
    in_rom   = ({1'b0, addr_q} < PROG_X);
    in_range = ({1'b0, addr_q} < DEPTH_X);
    complete = (state_q == BUSY) && (cnt_q == '0);
    // Reset on the completion edge must win so an aborted write never lands.
    ram_we   = complete && !rw_q && !in_rom && in_range && !reset;

    state_d = state_q;
    cnt_d   = cnt_q;
    mfc_d   = mfc_q;
    busy_d  = busy_q;
    dout_d  = dout_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef MEM_CTRL_ERR_EN
    err_d   = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (en) begin
          rw_d    = rw;
          addr_d  = addr;
          wdata_d = datain;
          cnt_d   = rw ? RD_CNT : WR_CNT;
          busy_d  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          mfc_d   = 1'b1;
          state_d = DONE;
          if (rw_q) dout_d = in_rom ? rom_word(addr_q) : (in_range ? ram_rdata : '0);
`ifdef MEM_CTRL_ERR_EN
          err_d   = (!rw_q && in_rom) || !in_range;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (!en) begin
          mfc_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
`ifdef MEM_CTRL_ERR_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mfc_q   <= 1'b0;
      busy_q  <= 1'b0;
      dout_q  <= '0;
`ifdef MEM_CTRL_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mfc_q   <= mfc_d;
      busy_q  <= busy_d;
      dout_q  <= dout_d;
`ifdef MEM_CTRL_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  // Request latches carry data only; they need no reset.
  always_ff @(posedge clk) begin
    rw_q    <= rw_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  mem_ctrl_array #(.DW(DW), .IW(IW), .DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .we    (ram_we),
    .idx   (addr_q[IW-1:0]),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  assign dataout = dout_q;
  assign mfc     = mfc_q;
  assign busy    = busy_q;
`ifdef MEM_CTRL_ERR_EN
  assign err     = err_q;
`endif

endmodule
